// File: rtl/vga_frame_scanner.sv
// -----------------------------------------------------------------------------
// vga_frame_scanner
//
// Streams an 8-bit grayscale framebuffer out with VGA timing (640x480@60 by
// default). Position counters drive a synchronous framebuffer read. The
// visible/sync terms are delayed two clocks, so colour and sync leave the block
// aligned. A frame position reaches r/g/b/hsync/vsync two clocks after the
// counters held it. After NUM_FRAMES complete frames and a two-cycle pipeline
// drain, the sticky done flag rises.
//
// Build option:
//   VGA_SCALE2X_EN - when defined, the framebuffer is a half-resolution image.
//                    Each source pixel covers a 2x2 block on screen.
//                    Address = (vcnt>>1)*(H_VIS/2) + (hcnt>>1).
//                    When undefined (default), mapping is 1:1.
//                    Address = vcnt*H_VIS + hcnt.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   start        one-cycle pulse; accepted in IDLE and DONE only
//   mem_addr     framebuffer read address; holds its value while mem_rd_en=0
//   mem_rd_en    read strobe, high for visible positions while scanning
//   mem_data     read data, valid one clock after mem_addr/mem_rd_en
//   hsync/vsync  active-low sync outputs
//   r/g/b        pixel colour; all three carry the same grey level
//   pixel_valid  high while r/g/b carry a visible pixel
//   done         sticky frame-complete flag
// -----------------------------------------------------------------------------
module vga_frame_scanner #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int NUM_FRAMES = 1,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              pixel_valid,
  output logic              done
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int FW    = $clog2(NUM_FRAMES + 1);

  // Counter-width copies of the timing boundaries keep every compare same-width.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [FW-1:0] F_LAST   = FW'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [HW-1:0]     hcnt_reg;
  logic [VW-1:0]     vcnt_reg;
  logic [FW-1:0]     frame_cnt_reg;
  logic              flush_cnt_reg;
  logic              done_reg;

  // Stage 0: combinational from the counters.
  logic              run0;
  logic              vis0;
  logic              hs0;
  logic              vs0;
  logic [ADDR_W-1:0] addr_calc;

  // Stage 1 and stage 2 (output) registers.
  logic              vis1_reg;
  logic              hs1_reg;
  logic              vs1_reg;
  logic              pixel_valid_reg;
  logic              hsync_reg;
  logic              vsync_reg;
  logic [7:0]        pix_reg;
  logic [ADDR_W-1:0] addr_last_reg;

  // ---------------------------------------------------------------------------
  // Control FSM and position counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      hcnt_reg      <= '0;
      vcnt_reg      <= '0;
      frame_cnt_reg <= '0;
      flush_cnt_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_RUN;
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            frame_cnt_reg <= '0;
          end
        end

        S_RUN: begin
          if (hcnt_reg == H_LAST) begin
            hcnt_reg <= '0;
            if (vcnt_reg == V_LAST) begin
              vcnt_reg      <= '0;
              frame_cnt_reg <= frame_cnt_reg + FW'(1);
              if (frame_cnt_reg == F_LAST) begin
                state_reg     <= S_FLUSH;
                flush_cnt_reg <= 1'b0;
              end
            end else begin
              vcnt_reg <= vcnt_reg + VW'(1);
            end
          end else begin
            hcnt_reg <= hcnt_reg + HW'(1);
          end
        end

        // Two idle cycles, so the last frame position leaves the output register.
        S_FLUSH: begin
          if (flush_cnt_reg) begin
            state_reg <= S_DONE;
          end else begin
            flush_cnt_reg <= 1'b1;
          end
        end

        S_DONE: begin
          done_reg <= 1'b1;
          if (start) begin
            state_reg     <= S_RUN;
            done_reg      <= 1'b0;
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            frame_cnt_reg <= '0;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: visibility, sync and address. The address and sync terms are only
  // active while scanning. In every other state the sync terms are inactive and
  // reads stop.
  // ---------------------------------------------------------------------------
  assign run0 = (state_reg == S_RUN);
  assign vis0 = run0 && (hcnt_reg < H_VIS_C) && (vcnt_reg < V_VIS_C);
  assign hs0  = !(run0 && (hcnt_reg >= HS_BEG) && (hcnt_reg < HS_END));
  assign vs0  = !(run0 && (vcnt_reg >= VS_BEG) && (vcnt_reg < VS_END));

`ifdef VGA_SCALE2X_EN
  assign addr_calc = ADDR_W'(vcnt_reg >> 1) * ADDR_W'(H_VIS / 2) + ADDR_W'(hcnt_reg >> 1);
`else
  assign addr_calc = ADDR_W'(vcnt_reg) * ADDR_W'(H_VIS) + ADDR_W'(hcnt_reg);
`endif

  assign mem_rd_en = vis0;
  // Between reads, the bus keeps showing the last address that was issued.
  assign mem_addr  = vis0 ? addr_calc : addr_last_reg;

  // ---------------------------------------------------------------------------
  // Stages 1 and 2. The RAM returns data during stage 1, so the output register
  // gates mem_data with the stage-1 copy of the visible flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      vis1_reg        <= 1'b0;
      hs1_reg         <= 1'b1;
      vs1_reg         <= 1'b1;
      pixel_valid_reg <= 1'b0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      pix_reg         <= 8'h00;
      addr_last_reg   <= '0;
    end else begin
      vis1_reg        <= vis0;
      hs1_reg         <= hs0;
      vs1_reg         <= vs0;
      pixel_valid_reg <= vis1_reg;
      hsync_reg       <= hs1_reg;
      vsync_reg       <= vs1_reg;
      pix_reg         <= vis1_reg ? mem_data : 8'h00;
      addr_last_reg   <= mem_addr;
    end
  end

  assign pixel_valid = pixel_valid_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign r           = pix_reg;
  assign g           = pix_reg;
  assign b           = pix_reg;
  assign done        = done_reg;

endmodule
